cache_sweep_controller: RTL and testbench

CACHE_SWEEP_CONTROLLER -- requirements
Module: cache_sweep_controller

---
 rtl/cache_sweep_controller_pkg.sv | 19 +
 rtl/cache_sweep_controller_if.sv | 21 ++
 rtl/cache_sweep_controller_rate_divider.sv | 73 +++++++
 rtl/cache_sweep_controller.sv | 127 ++++++++++++
 tb/tb_cache_sweep_controller.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_sweep_controller_pkg.sv
// Shared definitions for the cache sweep controller: FSM states, the percent
// scale and the width of the hit-rate quotient.
package cache_sweep_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam int PERCENT = 100;

  // hits*100 needs seven extra bits above the count width since 100 < 2^7
  function automatic int quotient_width(input int cnt_w);
    return cnt_w + 7;
  endfunction

endpackage

// File: rtl/cache_sweep_controller_if.sv
// Request/response bus between the sweep controller and the cache.
interface cache_sweep_controller_if #(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 14
);
  logic              cache_read;
  logic              cache_write;
  logic [ADDR_W-1:0] address;
  logic              cache_ready;
  logic [CNT_W-1:0]  hit_count;

  modport master (
    output cache_read, cache_write, address,
    input  cache_ready, hit_count
  );

  modport slave (
    input  cache_read, cache_write, address,
    output cache_ready, hit_count
  );
endinterface

// File: rtl/cache_sweep_controller_rate_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, W cycles per divide
// counting the start cycle. flush abandons a divide in flight; W must be >= 2.
module rate_divider #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] quotient
);

  localparam int CNT_BITS = $clog2(W + 1);

  logic [W-1:0]        rem;
  logic [W-1:0]        divisor_q;
  logic [CNT_BITS-1:0] steps_left;
  logic [W-1:0]        rem_in, quo_in, dvs;
  logic [W:0]          trial;
  logic [W-1:0]        rem_next, quo_next;

  // The start cycle already performs the first step on the fresh operands,
  // which is why a full divide occupies exactly W edges.
  always_comb begin
    rem_in = start ? '0 : rem;
    quo_in = start ? dividend : quotient;
    dvs    = start ? divisor : divisor_q;
    trial  = {rem_in, quo_in[W-1]};
    if (trial >= {1'b0, dvs}) begin
      rem_next = W'(trial - {1'b0, dvs});
      quo_next = {quo_in[W-2:0], 1'b1};
    end else begin
      rem_next = trial[W-1:0];
      quo_next = {quo_in[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem        <= '0;
      quotient   <= '0;
      divisor_q  <= '0;
      steps_left <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (flush) begin
        busy       <= 1'b0;
        steps_left <= '0;
      end else if (start) begin
        rem        <= rem_next;
        quotient   <= quo_next;
        divisor_q  <= divisor;
        steps_left <= CNT_BITS'(W - 1);
        busy       <= 1'b1;
      end else if (busy) begin
        rem        <= rem_next;
        quotient   <= quo_next;
        steps_left <= steps_left - CNT_BITS'(1);
        if (steps_left == CNT_BITS'(1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cache_sweep_controller.sv
// Walks a strided address range through the cache, then divides the cache's
// hit counter by the number of accesses to report a hit rate in percent.
module cache_sweep_controller
  import cache_sweep_controller_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 14,
  parameter int RATE_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        cfg_base,
  input  logic [ADDR_W-1:0]        cfg_stride,
  input  logic [CNT_W-1:0]         cfg_count,
  input  logic                     cfg_write,
  cache_sweep_controller_if.master bus,
  output logic [CNT_W-1:0]         access_count,
  output logic                     busy,
  output logic                     done,
  output logic [RATE_W-1:0]        hit_rate
);

  localparam int Q_W = quotient_width(CNT_W);

  sweep_state_t      state, next_state;
  logic [ADDR_W-1:0] addr_q, stride_q;
  logic [CNT_W-1:0]  count_q, hits_capped;
  logic              write_q, div_first;
  logic              accept_start, handshake, finish, div_start;
  logic              div_busy, div_valid;
  logic [Q_W-1:0]    dividend, div_quot;
  logic [RATE_W-1:0] rate_clamped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Abort outranks everything; start is only honoured while not busy.
  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    handshake    = 1'b0;
    finish       = 1'b0;
    div_start    = 1'b0;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            accept_start = 1'b1;
            next_state   = (cfg_count == '0) ? DONE : ACCESS;
          end
        end
        ACCESS: begin
          handshake = bus.cache_ready;
          if (handshake && ((access_count + CNT_W'(1)) == count_q))
            next_state = DIVIDE;
        end
        DIVIDE: begin
          div_start = div_first;
          if (!div_first && div_valid && !div_busy) begin
            finish     = 1'b1;
            next_state = DONE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // access_count is nonzero whenever DIVIDE runs, so the divisor is never zero
  always_comb begin
    hits_capped  = (bus.hit_count < access_count) ? bus.hit_count : access_count;
    dividend     = Q_W'(hits_capped) * Q_W'(PERCENT);
    rate_clamped = (div_quot > Q_W'(PERCENT)) ? RATE_W'(PERCENT) : div_quot[RATE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      stride_q     <= '0;
      count_q      <= '0;
      write_q      <= 1'b0;
      access_count <= '0;
      hit_rate     <= '0;
      div_first    <= 1'b0;
    end else begin
      div_first <= (state == ACCESS) && (next_state == DIVIDE);
      if (accept_start) begin
        addr_q       <= cfg_base;
        stride_q     <= cfg_stride;
        count_q      <= cfg_count;
        write_q      <= cfg_write;
        access_count <= '0;
        if (cfg_count == '0) hit_rate <= '0;
      end else if (handshake) begin
        addr_q       <= addr_q + stride_q;
        access_count <= access_count + CNT_W'(1);
      end else if (finish) begin
        hit_rate <= rate_clamped;
      end
    end
  end

  rate_divider #(.W(Q_W)) u_rate_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .flush    (abort),
    .dividend (dividend),
    .divisor  (Q_W'(access_count)),
    .busy     (div_busy),
    .valid    (div_valid),
    .quotient (div_quot)
  );

  assign bus.cache_read  = (state == ACCESS) && !write_q;
  assign bus.cache_write = (state == ACCESS) && write_q;
  assign bus.address     = addr_q;
  assign busy            = (state == ACCESS) || (state == DIVIDE);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_cache_sweep_controller.sv
// Scoreboard bench: stimulus queues the expected accesses and hit rates from
// a plain-arithmetic model, a negedge monitor compares what the DUT presents.
module tb_cache_sweep_controller;

  localparam int ADDR_W       = 15;
  localparam int CNT_W        = 14;
  localparam int RATE_W       = 7;
  localparam int ADDR_SPAN    = 1 << ADDR_W;
  localparam int DONE_LATENCY = CNT_W + 7 + 1;

  logic              clk, rst, start, abort, cfg_write;
  logic [ADDR_W-1:0] cfg_base, cfg_stride;
  logic [CNT_W-1:0]  cfg_count, access_count;
  logic              busy, done;
  logic [RATE_W-1:0] hit_rate;

  cache_sweep_controller_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

  cache_sweep_controller #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .RATE_W(RATE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_base     (cfg_base),
    .cfg_stride   (cfg_stride),
    .cfg_count    (cfg_count),
    .cfg_write    (cfg_write),
    .bus          (bus),
    .access_count (access_count),
    .busy         (busy),
    .done         (done),
    .hit_rate     (hit_rate)
  );

  typedef struct { int addr; bit wr; int idx; } acc_t;
  typedef struct { int rate; int cnt; bit timed; } res_t;

  acc_t acc_q[$];
  res_t res_q[$];
  int   total_checks = 0;
  int   passed_checks = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   last_rate = 0;
  bit   prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total_checks++;
    if (actual == expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Hit rate as a percentage of accesses; hits beyond the access count are capped.
  function automatic int ref_rate(input int hits, input int n);
    int h, r;
    if (n == 0) return 0;
    h = (hits < n) ? hits : n;
    r = (h * 100) / n;
    return (r > 100) ? 100 : r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input int base, input int stride, input int n, input bit wr);
    for (int i = 0; i < n; i++)
      acc_q.push_back('{addr: (base + i * stride) % ADDR_SPAN, wr: wr, idx: i});
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic applyStimulus(input int base, input int stride, input int n, input bit wr,
                               input int hits, input int mode, input bit poke);
    int k;
    push_expect(base, stride, n, wr);
    res_q.push_back('{rate: ref_rate(hits, n), cnt: n, timed: (n > 0)});
    last_rate       = ref_rate(hits, n);
    cfg_base        = ADDR_W'(base);
    cfg_stride      = ADDR_W'(stride);
    cfg_count       = CNT_W'(n);
    cfg_write       = wr;
    bus.hit_count   = CNT_W'(hits);
    bus.cache_ready = 1'b0;
    start           = 1'b1;
    tick();
    start = 1'b0;
    if (n > 0) begin
      checkOutput("done cleared by start", done, 0);
      checkOutput("busy after start", busy, 1);
    end
    k = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      case (mode)
        0:       bus.cache_ready = 1'b1;
        1:       bus.cache_ready = (k % 4 == 0) || (k % 4 == 3);
        default: bus.cache_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (poke && $urandom_range(0, 4) == 0) begin
        start      = 1'b1;
        cfg_base   = ADDR_W'($urandom);
        cfg_stride = ADDR_W'($urandom);
        cfg_count  = CNT_W'($urandom_range(0, 5));
        cfg_write  = ~wr;
      end
      k++;
      tick();
      start = 1'b0;
    end
    checkOutput("done reached within budget", done, 1);
  endtask

  // Monitor: every strobe cycle must present the next expected access.
  always @(negedge clk) begin : monitor
    acc_t e;
    res_t r;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (bus.cache_read || bus.cache_write) begin
        checkOutput("strobes exclusive", bus.cache_read && bus.cache_write, 0);
        if (acc_q.size() == 0) begin
          checkOutput("strobe with no access expected", 1, 0);
        end else begin
          e = acc_q[0];
          checkOutput("address", bus.address, e.addr);
          checkOutput("strobe kind", {bus.cache_read, bus.cache_write}, e.wr ? 1 : 2);
          checkOutput("access_count before handshake", access_count, e.idx);
          if (bus.cache_ready && !abort) begin
            void'(acc_q.pop_front());
            hs_cyc = cyc;
          end
        end
      end
      if (done && !prev_done) begin
        if (res_q.size() == 0) begin
          checkOutput("done with no result expected", 1, 0);
        end else begin
          r = res_q.pop_front();
          checkOutput("hit_rate", hit_rate, r.rate);
          checkOutput("access_count at done", access_count, r.cnt);
          if (r.timed) checkOutput("done latency after last handshake", cyc - hs_cyc - 1, DONE_LATENCY);
        end
      end
      prev_done = done;
    end
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, " cache_read"}, bus.cache_read, 0);
    checkOutput({tag, " cache_write"}, bus.cache_write, 0);
    checkOutput({tag, " address"}, bus.address, 0);
    checkOutput({tag, " access_count"}, access_count, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " hit_rate"}, hit_rate, 0);
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; abort = 1'b0; cfg_write = 1'b0;
    cfg_base = '0; cfg_stride = '0; cfg_count = '0;
    bus.cache_ready = 1'b0; bus.hit_count = '0;
    #1 rst = 1'b1;
    #2 checkReset("reset");
    #10 rst = 1'b0;
    tick();

    $display("[TB] directed sweeps");
    applyStimulus(1024, 1, 8, 1'b0, 6, 0, 1'b0);
    applyStimulus(200, 3, 6, 1'b0, 4, 1, 1'b0);
    applyStimulus(32766, 1, 4, 1'b0, 1, 0, 1'b0);
    applyStimulus(0, 5, 8, 1'b0, 20, 2, 1'b0);
    applyStimulus(500, 7, 4, 1'b1, 3, 0, 1'b1);

    $display("[TB] abort after three handshakes");
    push_expect(3000, 2, 10, 1'b0);
    cfg_base = ADDR_W'(3000); cfg_stride = ADDR_W'(2); cfg_count = CNT_W'(10);
    cfg_write = 1'b0; bus.hit_count = CNT_W'(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.cache_ready = 1'b1;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.cache_ready = 1'b0;
    checkOutput("abort cache_read", bus.cache_read, 0);
    checkOutput("abort cache_write", bus.cache_write, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort hit_rate kept", hit_rate, last_rate);
    checkOutput("abort handshakes consumed", acc_q.size(), 7);
    acc_q.delete();

    $display("[TB] zero-length sweep");
    applyStimulus(77, 1, 0, 1'b0, 5, 0, 1'b0);
    checkOutput("zero count done", done, 1);
    checkOutput("zero count hit_rate", hit_rate, 0);
    checkOutput("zero count access_count", access_count, 0);

    $display("[TB] random sweeps");
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(1, 24);
      applyStimulus($urandom_range(0, ADDR_SPAN - 1), $urandom_range(0, ADDR_SPAN - 1), n,
                    1'($urandom_range(0, 1)), $urandom_range(0, n + 5), 2, 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during divide");
    push_expect(40, 9, 2, 1'b1);
    cfg_base = ADDR_W'(40); cfg_stride = ADDR_W'(9); cfg_count = CNT_W'(2);
    cfg_write = 1'b1; bus.hit_count = CNT_W'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.cache_ready = 1'b1;
    repeat (2) tick();
    bus.cache_ready = 1'b0;
    repeat (5) tick();
    checkOutput("busy in divide", busy, 1);
    #3 rst = 1'b1;
    #1 checkReset("reset mid-divide");
    last_rate = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    checkOutput("no strobe after reset release", bus.cache_read || bus.cache_write, 0);
    checkOutput("idle after reset release", busy || done, 0);

    repeat (2) tick();
    checkOutput("all expected accesses seen", acc_q.size(), 0);
    checkOutput("all expected results seen", res_q.size(), 0);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
